// File: rtl/flash_adc_backend.sv
// Flash ADC digital back-end: 2-flop synchroniser, majority bubble correction,
// thermometer-to-binary popcount, power-of-two averaging with rounding, and a
// valid/ready result register with sticky bubble/overrun flags.
module flash_adc_backend #(
    parameter int unsigned NCOMP    = 7,
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned DIV_W    = 8,
    localparam int unsigned OUT_W   = $clog2(NCOMP + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ena,
    input  logic [NCOMP-1:0] i_therm_in,
    input  logic [DIV_W-1:0] i_sample_div,
    input  logic             i_continuous,
    input  logic             i_start,
    output logic [OUT_W-1:0] o_result,
    output logic             o_result_valid,
    input  logic             i_result_ready,
    output logic             o_bubble_err,
    output logic             o_overrun,
    input  logic             i_clear_flags,
    output logic             o_busy
);

    localparam int unsigned ACC_W = OUT_W + AVG_LOG2;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAcq,
        StDone
    } state_t;

    state_t           r_state;
    logic [NCOMP-1:0] r_sync1;
    logic [NCOMP-1:0] r_sync2;
    logic [DIV_W-1:0] r_div;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_result;
    logic             r_valid;
    logic             r_bubble_err;
    logic             r_overrun;
    logic             r_busy;

    logic [NCOMP+1:0] w_ext;
    logic [NCOMP-1:0] w_corr;
    logic [OUT_W-1:0] w_code;
    logic [OUT_W-1:0] w_rounded;
    logic             w_strobe;
    logic             w_bubble;

    // Two-flop synchroniser; keeps sampling even while the block is disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_therm_in;
            r_sync2 <= r_sync1;
        end
    end

    // Bubble correction: 3-input majority with an implied 1 below and 0 above.
    always_comb begin
        w_ext  = {1'b0, r_sync2, 1'b1};
        w_corr = '0;
        for (int i = 0; i < int'(NCOMP); i++) begin
            w_corr[i] = (w_ext[i] & w_ext[i+1]) | (w_ext[i] & w_ext[i+2]) |
                        (w_ext[i+1] & w_ext[i+2]);
        end
    end

    // Popcount of the corrected thermometer code.
    always_comb begin
        w_code = '0;
        for (int i = 0; i < int'(NCOMP); i++) begin
            w_code = w_code + OUT_W'(w_corr[i]);
        end
    end

    assign w_bubble = (w_corr != r_sync2);
    assign w_strobe = (r_state == StAcq) && (r_div == i_sample_div);

    // Round-half-up average; the sum cannot overflow ACC_W since acc <= NCOMP*2^AVG_LOG2.
    if (AVG_LOG2 == 0) begin : g_no_avg
        assign w_rounded = r_acc;
    end else begin : g_avg
        logic [ACC_W-1:0] w_acc_rnd;
        assign w_acc_rnd = r_acc + ACC_W'(1 << (AVG_LOG2 - 1));
        assign w_rounded = OUT_W'(w_acc_rnd >> AVG_LOG2);
    end

    // Conversion FSM, divider, accumulator, result register and sticky flags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_div        <= '0;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_valid      <= 1'b0;
            r_bubble_err <= 1'b0;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            // The handshake completes regardless of enable; a DONE load below overrides.
            if (r_valid && i_result_ready) begin
                r_valid <= 1'b0;
            end
            if (i_ena) begin
                // Clear first so that a set in the same cycle takes precedence.
                if (i_clear_flags) begin
                    r_bubble_err <= 1'b0;
                    r_overrun    <= 1'b0;
                end
                unique case (r_state)
                    StIdle: begin
                        if (i_continuous || i_start) begin
                            r_state <= StAcq;
                            r_div   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    StAcq: begin
                        if (w_strobe) begin
                            r_div <= '0;
                            r_acc <= r_acc + ACC_W'(w_code);
                            r_cnt <= r_cnt + 1'b1;
                            if (w_bubble) begin
                                r_bubble_err <= 1'b1;
                            end
                            if (r_cnt == CNT_LAST) begin
                                r_state <= StDone;
                            end
                        end else begin
                            r_div <= r_div + 1'b1;
                        end
                    end
                    StDone: begin
                        r_acc <= '0;
                        r_cnt <= '0;
                        r_div <= '0;
                        if (i_continuous) begin
                            r_state <= StAcq;
                        end else begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                        // Old unaccepted result is kept; the new one is dropped.
                        if (!r_valid || i_result_ready) begin
                            r_result <= w_rounded;
                            r_valid  <= 1'b1;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_result       = r_result;
    assign o_result_valid = r_valid;
    assign o_bubble_err   = r_bubble_err;
    assign o_overrun      = r_overrun;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_flash_adc_backend.sv
// Directed testbench for flash_adc_backend (NCOMP=7, AVG_LOG2=2, DIV_W=8).
module tb_flash_adc_backend;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [6:0] therm;
    logic [7:0] sample_div;
    logic       continuous;
    logic       start;
    logic [2:0] result;
    logic       valid;
    logic       ready;
    logic       bubble;
    logic       overrun;
    logic       clear_flags;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int gap;
    int n;

    flash_adc_backend #(
        .NCOMP   (7),
        .AVG_LOG2(2),
        .DIV_W   (8)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_ena         (ena),
        .i_therm_in    (therm),
        .i_sample_div  (sample_div),
        .i_continuous  (continuous),
        .i_start       (start),
        .o_result      (result),
        .o_result_valid(valid),
        .i_result_ready(ready),
        .o_bubble_err  (bubble),
        .o_overrun     (overrun),
        .i_clear_flags (clear_flags),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Polls on negedges until valid is seen or the budget expires.
    task automatic wait_valid(input string tag, input int max_cyc, output int cycles);
        cycles = 0;
        while (cycles < max_cyc) begin
            @(negedge clk);
            cycles++;
            if (valid === 1'b1) break;
        end
        check({tag, "_timeout"}, {31'd0, valid}, 32'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        ena         = 1'b1;
        therm       = 7'b0011111;
        sample_div  = 8'd3;
        continuous  = 1'b0;
        start       = 1'b0;
        ready       = 1'b1;
        clear_flags = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_result", result, 0);
        check("rst_valid", valid, 0);
        check("rst_bubble", bubble, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);

        // Continuous, code 5, sample_div=3
        continuous = 1'b1;
        rst_n      = 1'b1;
        wait_valid("cont1", 40, cyc);
        check("cont1_result", result, 5);
        check("cont1_bubble", bubble, 0);
        check("cont1_busy", busy, 1);
        wait_valid("cont2", 40, gap);
        check("cont2_period", ((gap == 16) || (gap == 17)) ? 1 : 0, 1);
        check("cont2_result", result, 5);

        // Bubble at bit 2 corrects to 0011111
        therm = 7'b0011011;
        wait_valid("bub1", 40, cyc);
        wait_valid("bub2", 40, cyc);
        check("bub_result", result, 5);
        check("bub_flag_set", bubble, 1);
        therm = 7'b0011111;
        repeat (4) @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check("bub_flag_clr", bubble, 0);
        wait_valid("bub3", 40, cyc);
        check("bub3_result", result, 5);
        check("bub3_flag", bubble, 0);

        // Leave continuous mode; current window completes
        continuous = 1'b0;
        for (int i = 0; i < 60 && busy; i++) @(negedge clk);
        check("idle_busy", busy, 0);
        repeat (3) @(negedge clk);
        check("idle_valid", valid, 0);

        // Rounding: codes 3,3,4,4 -> (14+2)>>2 = 4; strobes every 10 cycles
        sample_div = 8'd9;
        therm      = 7'b0000111;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (22) @(negedge clk);
        therm = 7'b0001111;
        wait_valid("rnd", 40, cyc);
        check("rnd_result", result, 4);
        check("rnd_busy", busy, 0);
        check("rnd_bubble", bubble, 0);

        // Single-shot, sample_div=0, codes 7 x4 -> 7
        sample_div = 8'd0;
        therm      = 7'b1111111;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid("ss", 20, cyc);
        check("ss_latency", cyc, 5);
        check("ss_result", result, 7);
        check("ss_busy", busy, 0);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid) n++;
        end
        check("ss_no_more", n, 0);
        check("ss_busy_after", busy, 0);

        // Backpressure: sample_div=1 gives a 9-cycle window (8 ACQ + DONE)
        ready      = 1'b0;
        sample_div = 8'd1;
        therm      = 7'b0011111;
        repeat (3) @(negedge clk);
        continuous = 1'b1;
        wait_valid("bp1", 40, cyc);
        check("bp1_result", result, 5);
        check("bp1_overrun", overrun, 0);
        therm = 7'b0000011;
        repeat (19) @(negedge clk);
        check("bp_overrun_set", overrun, 1);
        check("bp_held_result", result, 5);
        check("bp_held_valid", valid, 1);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        check("bp_overrun_clr", overrun, 0);
        repeat (6) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        check("bp_coinc_valid", valid, 1);
        check("bp_coinc_result", result, 2);
        check("bp_coinc_overrun", overrun, 0);
        @(negedge clk);
        check("bp_xfer_valid", valid, 0);

        // Reset mid-ACQ after two strobes, then restart with code 1
        sample_div = 8'd3;
        therm      = 7'b0111111;
        wait_valid("pre1", 60, cyc);
        wait_valid("pre2", 60, cyc);
        check("pre_result", result, 6);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_result", result, 0);
        check("arst_valid", valid, 0);
        check("arst_busy", busy, 0);
        check("arst_overrun", overrun, 0);
        check("arst_bubble", bubble, 0);
        therm = 7'b0000001;
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid("post", 40, cyc);
        check("post_result", result, 1);

        // Enable low freezes the conversion
        ena = 1'b0;
        n   = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) n++;
        end
        check("ena_frozen", n, 0);
        check("ena_busy", busy, 1);
        ena = 1'b1;
        wait_valid("ena_resume", 40, cyc);
        check("ena_result", result, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
